// File: rtl/cordic_pkg.sv
// Purpose : shared types and constants for the CORDIC controller block.
// Contents: FSM state enum, Q2.30 format constants, canonical NaN,
//           default iteration count, and the float range-check helper.
package cordic_pkg;

  // Controller states, in sequencing order.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ITER = 3'd2,
    ST_PACK = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Signed fixed-point angle format fed to the datapath: 2 integer bits
  // (including sign) and 30 fraction bits, covering [-2, 2).
  localparam int Q_WIDTH = 32;
  localparam int Q_FRAC  = 30;

  // Quiet NaN returned for operands the controller refuses to process.
  localparam logic [31:0] NAN_CANON = 32'h7FC0_0000;

  // Default number of CORDIC micro-rotations.
  localparam int N_ITER_DEFAULT = 22;

  // True when |f| > 1.0, including Inf and NaN (exponent field 255 is
  // already greater than 127, so no separate test is needed for them).
  function automatic logic float_out_of_range(input logic [31:0] f);
    logic [7:0]  e;
    logic [22:0] m;
    e = f[30:23];
    m = f[22:0];
    return (e > 8'd127) || ((e == 8'd127) && (m != 23'd0));
  endfunction

endpackage

// File: rtl/cordic_ctrl_unpack.sv
// Purpose : convert an IEEE-754 single into a signed Q2.30 angle.
// Latency : purely combinational; no backpressure (always ready).
// Ports   : fp  - IEEE-754 single operand
//           q   - signed Q2.30 value, truncated toward zero in magnitude,
//                 saturated to the format limits when |fp| >= 2 or Inf/NaN
module cordic_ctrl_unpack
  import cordic_pkg::*;
(
  input  logic [31:0]        fp,
  output logic [Q_WIDTH-1:0] q
);

  // value * 2^Q_FRAC = sig * 2^(exp - 127 - 23 + Q_FRAC), so the exponent at
  // which the 24-bit significand needs no shift is 150 - Q_FRAC.
  localparam logic [7:0] UNP_BIAS = 8'(150 - Q_FRAC);
  // Largest exponent that still fits below 2.0 in Q2.30.
  localparam logic [7:0] EXP_MAX  = 8'd127;

  logic              sgn;
  logic [7:0]        expo;
  logic [22:0]       mant;
  logic [31:0]       sig;
  logic [31:0]       mag;
  logic              sat;

  always_comb begin
    sgn  = fp[31];
    expo = fp[30:23];
    mant = fp[22:0];
    // Denormals get no hidden bit; they shift out to zero anyway.
    sig  = {8'd0, (expo != 8'd0), mant};
    sat  = 1'b0;
    mag  = 32'd0;

    if (expo > EXP_MAX) begin
      sat = 1'b1;
    end else if (expo >= UNP_BIAS) begin
      // At most 7 places left: 24 + 7 = 31 bits, so the sign bit stays clear.
      mag = sig << (expo - UNP_BIAS);
    end else begin
      mag = sig >> (UNP_BIAS - expo);
    end

    if (sat) begin
      q = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (sgn) begin
      q = 32'd0 - mag;
    end else begin
      q = mag;
    end
  end

endmodule

// File: rtl/cordic_ctrl.sv
// Purpose : sequencing controller for an external iterative CORDIC datapath
//           (unpack -> load -> N_ITER steps -> pack wait -> done pulse).
// Latency : done N_ITER+RESULT_WAIT+2 enabled cycles after an accepted start;
//           clk_en=0 freezes everything and masks all strobes.
// Backpressure: none; start is only honoured in IDLE and is never queued.
// Ports   : clk, reset_n (sync, active-low), clk_en, start, dataa (float in)
//           done, result, busy, range_err   - completion side
//           dp_load, dp_theta, dp_step, dp_iter, dp_result - datapath side
// Config  : define CORDIC_CTRL_RANGE_CHECK_EN to reject |dataa| > 1 with a
//           NaN result and range_err=1 (no datapath activity).
module cordic_ctrl
  import cordic_pkg::*;
#(
  parameter int N_ITER      = N_ITER_DEFAULT,
  parameter int RESULT_WAIT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clk_en,
  input  logic               start,
  input  logic [31:0]        dataa,
  output logic               done,
  output logic [31:0]        result,
  output logic               busy,
  output logic               range_err,
  output logic               dp_load,
  output logic [Q_WIDTH-1:0] dp_theta,
  output logic               dp_step,
  output logic [4:0]         dp_iter,
  input  logic [31:0]        dp_result
);

  localparam logic [4:0] ITER_LAST = 5'(N_ITER - 1);
  localparam logic [2:0] WAIT_LAST = 3'(RESULT_WAIT - 1);

  state_t             state;
  logic               load_q;
  logic               step_q;
  logic               done_q;
  logic [2:0]         wait_cnt;
  logic [Q_WIDTH-1:0] theta_unp;

  cordic_ctrl_unpack u_unpack (
    .fp (dataa),
    .q  (theta_unp)
  );

`ifdef CORDIC_CTRL_RANGE_CHECK_EN
  logic rerr_q;
  logic oor;
  assign oor       = float_out_of_range(dataa);
  assign range_err = rerr_q;
`else
  assign range_err = 1'b0;
`endif

  // Strobes are held in registers so a stall resumes with the same strobe;
  // masking them here keeps every strobe aligned with an advancing cycle.
  assign dp_load = load_q & clk_en;
  assign dp_step = step_q & clk_en;
  assign done    = done_q & clk_en;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      load_q   <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      wait_cnt <= 3'd0;
      dp_iter  <= 5'd0;
      dp_theta <= '0;
      result   <= 32'd0;
`ifdef CORDIC_CTRL_RANGE_CHECK_EN
      rerr_q   <= 1'b0;
`endif
    end else if (clk_en) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            dp_theta <= theta_unp;
            dp_iter  <= 5'd0;
`ifdef CORDIC_CTRL_RANGE_CHECK_EN
            if (oor) begin
              // Rejected operand: skip the datapath entirely.
              state  <= ST_DONE;
              done_q <= 1'b1;
              result <= NAN_CANON;
              rerr_q <= 1'b1;
            end else begin
              state  <= ST_LOAD;
              load_q <= 1'b1;
            end
`else
            state  <= ST_LOAD;
            load_q <= 1'b1;
`endif
          end
        end

        ST_LOAD: begin
          load_q <= 1'b0;
          step_q <= 1'b1;
          state  <= ST_ITER;
        end

        ST_ITER: begin
          if (dp_iter == ITER_LAST) begin
            step_q   <= 1'b0;
            dp_iter  <= 5'd0;
            wait_cnt <= 3'd0;
            state    <= ST_PACK;
          end else begin
            dp_iter <= dp_iter + 5'd1;
          end
        end

        ST_PACK: begin
          if (wait_cnt == WAIT_LAST) begin
            result <= dp_result;
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        ST_DONE: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
`ifdef CORDIC_CTRL_RANGE_CHECK_EN
          rerr_q <= 1'b0;
`endif
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_ctrl.sv
// Purpose : self-checking bench for cordic_ctrl at default parameters.
// Ports   : none; drives the DUT and plays the role of the datapath.
// Config  : expectations follow CORDIC_CTRL_RANGE_CHECK_EN if defined.
module tb_cordic_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataa = 32'd0;
  logic [31:0] dp_result = 32'd0;
  logic        done;
  logic [31:0] result;
  logic        busy;
  logic        range_err;
  logic        dp_load;
  logic [31:0] dp_theta;
  logic        dp_step;
  logic [4:0]  dp_iter;

  cordic_ctrl #(.N_ITER(22), .RESULT_WAIT(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clk_en    (clk_en),
    .start     (start),
    .dataa     (dataa),
    .done      (done),
    .result    (result),
    .busy      (busy),
    .range_err (range_err),
    .dp_load   (dp_load),
    .dp_theta  (dp_theta),
    .dp_step   (dp_step),
    .dp_iter   (dp_iter),
    .dp_result (dp_result)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Observations of one run, cycle numbers relative to the start cycle t0.
  int          load_c, n_load, step_first, step_last, n_step;
  int          done_c, done_last, n_done, iter_err, stall_err, rst_c;
  logic [31:0] theta_c1, res_at_done, theta_end, res_end;
  logic [31:0] theta_after_rst, iter_after_rst;
  logic        rerr_at_done, busy_first, busy_end, busy_after_rst;

  // Called at a point inside cycle t0; start is sampled at the end of t0.
  // pulse_a/pulse_b: extra cycles with start=1; stall_c: first of 3 cycles
  // with clk_en=0; do_rst: one reset cycle when dp_iter==10 is stepped.
  task automatic run(input logic [31:0] a, input logic [31:0] pr, input int stall_c,
                     input int pulse_a, input int pulse_b, input bit do_rst);
    int exp_iter;
    exp_iter = 0;
    load_c = -1; n_load = 0; step_first = -1; step_last = -1; n_step = 0;
    done_c = -1; done_last = -1; n_done = 0; iter_err = 0; stall_err = 0; rst_c = -1;
    rerr_at_done = 1'b0; res_at_done = 32'd0; busy_after_rst = 1'b1;
    theta_after_rst = 32'hFFFF_FFFF; iter_after_rst = 32'hFFFF_FFFF;
    dataa = a;
    dp_result = pr;
    start = 1'b1;
    clk_en = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      start   = (c == pulse_a) || (c == pulse_b);
      clk_en  = !((stall_c > 0) && (c >= stall_c) && (c <= stall_c + 2));
      #1;
      if (c == 1) begin
        theta_c1   = dp_theta;
        busy_first = busy;
      end
      if (!clk_en && (dp_load || dp_step || done)) stall_err++;
      if (dp_load) begin
        n_load++;
        if (load_c < 0) load_c = c;
      end
      if (dp_step) begin
        n_step++;
        if (step_first < 0) step_first = c;
        step_last = c;
        if (dp_iter !== 5'(exp_iter)) iter_err++;
        exp_iter++;
      end
      if (done) begin
        n_done++;
        done_last = c;
        if (done_c < 0) begin
          done_c       = c;
          res_at_done  = result;
          rerr_at_done = range_err;
        end
      end
      if (rst_c >= 0 && c == rst_c + 1) begin
        busy_after_rst  = busy;
        theta_after_rst = dp_theta;
        iter_after_rst  = {27'd0, dp_iter};
      end
      if (do_rst && rst_c < 0 && dp_step && dp_iter == 5'd10) begin
        // Reset with clk_en low as well: reset must not depend on enable.
        reset_n = 1'b0;
        clk_en  = 1'b0;
        rst_c   = c;
      end
    end
    theta_end = dp_theta;
    res_end   = result;
    busy_end  = busy;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] pr;
    logic [31:0] theta;
    bit          chk_theta;
    bit          big;        // |a| > 1: rejected when the range check is built in
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit          oor;
    logic [31:0] exp_res;

    vecs[0] = '{32'h3F80_0000, 32'hA500_0001, 32'h4000_0000, 1'b1, 1'b0}; //  1.0
    vecs[1] = '{32'hBF80_0000, 32'hA500_0002, 32'hC000_0000, 1'b1, 1'b0}; // -1.0
    vecs[2] = '{32'h0000_0000, 32'hA500_0003, 32'h0000_0000, 1'b1, 1'b0}; //  0.0
    vecs[3] = '{32'h3F00_0000, 32'hA500_0004, 32'h2000_0000, 1'b1, 1'b0}; //  0.5
    vecs[4] = '{32'hBE80_0000, 32'hA500_0005, 32'hF000_0000, 1'b1, 1'b0}; // -0.25
    vecs[5] = '{32'h2B80_0000, 32'hA500_0006, 32'h0000_0000, 1'b1, 1'b0}; //  2^-40
    vecs[6] = '{32'h3FC0_0000, 32'hA500_0007, 32'h6000_0000, 1'b1, 1'b1}; //  1.5
    vecs[7] = '{32'h4000_0000, 32'hA500_0008, 32'h0000_0000, 1'b0, 1'b1}; //  2.0
    vecs[8] = '{32'h7FC0_0000, 32'hA500_0009, 32'h0000_0000, 1'b0, 1'b1}; //  NaN

    // Reset with clk_en low, then check every reset value.
    reset_n = 1'b0;
    clk_en  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_range_err", {31'd0, range_err}, 32'd0);
    check("rst_dp_load", {31'd0, dp_load}, 32'd0);
    check("rst_dp_step", {31'd0, dp_step}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_dp_theta", dp_theta, 32'd0);
    check("rst_dp_iter", {27'd0, dp_iter}, 32'd0);
    reset_n = 1'b1;
    clk_en  = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
`ifdef CORDIC_CTRL_RANGE_CHECK_EN
      oor = vecs[i].big;
`else
      oor = 1'b0;
`endif
      exp_res = oor ? 32'h7FC0_0000 : vecs[i].pr;
      run(vecs[i].a, vecs[i].pr, 0, 0, 0, 1'b0);
      check($sformatf("v%0d_n_done", i), n_done, 1);
      check($sformatf("v%0d_busy_c1", i), {31'd0, busy_first}, 32'd1);
      check($sformatf("v%0d_result", i), res_at_done, exp_res);
      check($sformatf("v%0d_result_held", i), res_end, exp_res);
      check($sformatf("v%0d_range_err", i), {31'd0, rerr_at_done}, {31'd0, oor});
      check($sformatf("v%0d_busy_end", i), {31'd0, busy_end}, 32'd0);
      if (vecs[i].chk_theta) begin
        check($sformatf("v%0d_theta", i), theta_c1, vecs[i].theta);
        check($sformatf("v%0d_theta_held", i), theta_end, vecs[i].theta);
      end
      if (oor) begin
        check($sformatf("v%0d_done_cycle", i), done_c, 1);
        check($sformatf("v%0d_n_load", i), n_load, 0);
        check($sformatf("v%0d_n_step", i), n_step, 0);
      end else begin
        check($sformatf("v%0d_done_cycle", i), done_c, 25);
        check($sformatf("v%0d_load_cycle", i), load_c, 1);
        check($sformatf("v%0d_n_load", i), n_load, 1);
        check($sformatf("v%0d_step_first", i), step_first, 2);
        check($sformatf("v%0d_step_last", i), step_last, 23);
        check($sformatf("v%0d_n_step", i), n_step, 22);
        check($sformatf("v%0d_iter_seq_err", i), iter_err, 0);
      end
    end

    // Three disabled cycles in the middle of ITER.
    run(32'h3F80_0000, 32'h1111_2222, 10, 0, 0, 1'b0);
    check("stall_done_cycle", done_c, 28);
    check("stall_step_first", step_first, 2);
    check("stall_step_last", step_last, 26);
    check("stall_n_step", n_step, 22);
    check("stall_iter_seq_err", iter_err, 0);
    check("stall_strobe_while_off", stall_err, 0);
    check("stall_result", res_at_done, 32'h1111_2222);

    // Reset for one cycle while dp_iter=10 is being stepped.
    run(32'h3F00_0000, 32'h3333_4444, 0, 0, 0, 1'b1);
    check("abort_rst_cycle", rst_c, 12);
    check("abort_busy_after", {31'd0, busy_after_rst}, 32'd0);
    check("abort_iter_after", iter_after_rst, 32'd0);
    check("abort_theta_after", theta_after_rst, 32'd0);
    check("abort_n_done", n_done, 0);
    check("abort_n_step", n_step, 11);
    run(32'h3F80_0000, 32'h5555_6666, 0, 0, 0, 1'b0);
    check("post_abort_done_cycle", done_c, 25);
    check("post_abort_result", res_at_done, 32'h5555_6666);

    // start pulses during ITER and during DONE are dropped, not queued.
    run(32'hBF80_0000, 32'h7777_8888, 0, 10, 25, 1'b0);
    check("ignore_n_done", n_done, 1);
    check("ignore_done_cycle", done_c, 25);
    check("ignore_n_load", n_load, 1);
    check("ignore_busy_end", {31'd0, busy_end}, 32'd0);

    // start in the first IDLE cycle after DONE is accepted.
    run(32'h0000_0000, 32'h9999_AAAA, 0, 26, 0, 1'b0);
    check("b2b_n_done", n_done, 2);
    check("b2b_first_done", done_c, 25);
    check("b2b_second_done", done_last, 51);
    check("b2b_n_load", n_load, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_ctrl.md
CORDIC_CTRL -- requirements
Module: cordic_ctrl

Interface
REQ-001 SHALL have parameter N_ITER, default 22, number of CORDIC iterations (1..31).
REQ-002 SHALL have parameter RESULT_WAIT, default 1, cycles allowed for the downstream packer (1..7).
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port clk_en  in  1  global advance enable.
REQ-006 SHALL have port start  in  1  request, sampled in IDLE.
REQ-007 SHALL have port dataa  in  32  IEEE-754 single operand (angle).
REQ-008 SHALL have port done  out  1  one-cycle completion pulse.
REQ-009 SHALL have port result  out  32  packed float result, valid while done=1.
REQ-010 SHALL have port busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port range_err  out  1  out-of-range flag, valid while done=1.
REQ-012 SHALL have port dp_load  out  1  one-cycle load strobe to the CORDIC datapath.
REQ-013 SHALL have port dp_theta  out  32  signed Q2.30 angle, from the existing unpacker.
REQ-014 SHALL have port dp_step  out  1  iteration-advance strobe.
REQ-015 SHALL have port dp_iter  out  5  current iteration index.
REQ-016 SHALL have port dp_result  in  32  packed float from the datapath/packer.

Function
REQ-017 SHALL implement the FSM states IDLE, LOAD, ITER, PACK and DONE.
REQ-018 SHALL advance the FSM, counters and registers only on cycles with clk_en=1; with clk_en=0, all state holds and dp_load, dp_step and done are forced to 0.
REQ-019 IDLE: on start=1, SHALL register the unpacked dataa into dp_theta and go to LOAD.
REQ-020 LOAD: SHALL assert dp_load=1 with dp_iter=0 for one cycle, then go to ITER.
REQ-021 ITER: SHALL assert dp_step=1 for N_ITER cycles, with dp_iter counting 0..N_ITER-1 (no skips or repeats), then go to PACK.
REQ-022 PACK: SHALL wait RESULT_WAIT cycles, then go to DONE, registering dp_result into result on that transition.
REQ-023 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-024 SHALL assert done N_ITER+RESULT_WAIT+2 enabled cycles after the start cycle (25 cycles at the defaults).
REQ-025 SHALL ignore start in every state except IDLE, and SHALL NOT queue it.
REQ-026 SHALL keep dp_theta and result unchanged until the next accepted start or done respectively.
REQ-027 SHALL accept a new start no earlier than the cycle after DONE, with no back-to-back overlap.

Reset
REQ-028 SHALL respond to reset_n=0 at a rising edge regardless of clk_en: state to IDLE, counters to 0, outputs done/busy/range_err/dp_load/dp_step to 0, and result/dp_theta/dp_iter to 0.
REQ-029 SHALL abort any in-flight operation on reset, producing no done.

Configuration
REQ-030 With CORDIC_CTRL_RANGE_CHECK_EN defined, SHALL classify any dataa with |x|>1 (exponent>127, exponent=127 with mantissa!=0, Inf or NaN) as out of range when start is accepted.
REQ-031 With CORDIC_CTRL_RANGE_CHECK_EN defined, SHALL send an out-of-range operand from IDLE straight to DONE with result=32'h7FC00000 and range_err=1, and SHALL NOT assert dp_load or dp_step.
REQ-032 Without CORDIC_CTRL_RANGE_CHECK_EN, SHALL omit the check, SHALL tie range_err to 0, and SHALL sequence every operand normally.

Structure
REQ-033 SHALL take the following from shared package cordic_pkg: FSM state enum, Q2.30 width/fraction constants, canonical NaN constant 32'h7FC00000, N_ITER default, and the float range-check function.
REQ-034 SHALL instantiate the existing unpacker as its only sub-module; the iteration datapath and packer SHALL stay outside the block.

Verification
REQ-035 dataa=32'h3F800000 (1.0), start at t0 -> dp_theta=32'h40000000 with dp_load at t0+1, dp_step over t0+2..t0+23, done at t0+25, result equal to dp_result.
REQ-036 dataa=32'hBF800000 (-1.0) then dataa=32'h0 -> dp_theta=32'hC0000000 then 32'h00000000; range_err=0 in both runs.
REQ-037 With the macro, dataa=32'h40000000 (2.0) -> done at t0+1 with result=32'h7FC00000 and range_err=1, no dp_load; without the macro -> the normal 25-cycle run.
REQ-038 clk_en=0 for 3 cycles during ITER -> done at t0+28, dp_iter sequence contiguous, dp_step=0 while clk_en=0.
REQ-039 reset_n=0 for one cycle at dp_iter=10 -> busy=0 next cycle, no done, and a subsequent start completes after 25 cycles.
REQ-040 start pulsed during ITER and during DONE -> ignored, exactly one done per accepted start.
